// File: rtl/wb_regfile_unit.sv
//==============================================================================
// Module : wb_regfile_unit
// Desc   : Writeback commit stage with the ARM register file, NZCV flags and
//          the same-cycle write-through bypass for the decode read ports.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_regfile_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_INDEX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_enable_in,
  input  logic                  mem_to_reg_select_in,
  input  logic                  status_bits_in,
  input  logic [ADDR_WIDTH-1:0] wb_rd_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [3:0]            flags_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  input  logic [ADDR_WIDTH-1:0] raddr_c,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic [3:0]            flags_out,
  output logic [3:0]            cond_flags,
  output logic                  pc_write_out,
  output logic [DATA_WIDTH-1:0] pc_write_data,
  output logic                  wb_valid_out,
  output logic [ADDR_WIDTH-1:0] wb_rd_out,
  output logic [DATA_WIDTH-1:0] wb_data_out
);

  localparam int              C_NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_PC_IDX = ADDR_WIDTH'(PC_INDEX);

  logic [DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
  logic [3:0]            r_nzcv;
  logic                  r_pc_write;
  logic [DATA_WIDTH-1:0] r_pc_data;
  logic                  r_wb_valid;
  logic [ADDR_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_rd_is_pc;
  logic                  w_gpr_write;
  logic [ADDR_WIDTH-1:0] w_raddr [3];
  logic [DATA_WIDTH-1:0] w_rdata [3];

  assign w_wb_data   = mem_to_reg_select_in ? mem_data_in : alu_result_in;
  assign w_rd_is_pc  = (wb_rd_in == C_PC_IDX);
  assign w_gpr_write = reg_write_enable_in && !w_rd_is_pc;

  assign w_raddr[0] = raddr_a;
  assign w_raddr[1] = raddr_b;
  assign w_raddr[2] = raddr_c;

  // PC reads win over the bypass so a branch-to-PC write never leaks into R15 reads.
  generate
    for (genvar p = 0; p < 3; p++) begin : g_read
      always_comb begin
        if (w_raddr[p] == C_PC_IDX)
          w_rdata[p] = pc_in;
        else if (reg_write_enable_in && (wb_rd_in == w_raddr[p]))
          w_rdata[p] = w_wb_data;
        else
          w_rdata[p] = r_regs[w_raddr[p]];
      end
    end
  endgenerate

  assign rdata_a = w_rdata[0];
  assign rdata_b = w_rdata[1];
  assign rdata_c = w_rdata[2];

  assign cond_flags    = status_bits_in ? flags_in : r_nzcv;
  assign flags_out     = r_nzcv;
  assign pc_write_out  = r_pc_write;
  assign pc_write_data = r_pc_data;
  assign wb_valid_out  = r_wb_valid;
  assign wb_rd_out     = r_wb_rd;
  assign wb_data_out   = r_wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_NUM_REGS; i++) r_regs[i] <= '0;
      r_nzcv     <= '0;
      r_pc_write <= 1'b0;
      r_pc_data  <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      if (w_gpr_write) begin
        r_regs[wb_rd_in] <= w_wb_data;
        r_wb_rd          <= wb_rd_in;
        r_wb_data        <= w_wb_data;
      end
      r_wb_valid <= w_gpr_write;
      r_pc_write <= reg_write_enable_in && w_rd_is_pc;
      if (reg_write_enable_in && w_rd_is_pc)
        r_pc_data <= w_wb_data;
      if (status_bits_in)
        r_nzcv <= flags_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
//==============================================================================
// Module : tb_wb_regfile_unit
// Desc   : Directed self-checking bench for wb_regfile_unit.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_wb_regfile_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_enable_in;
  logic        mem_to_reg_select_in;
  logic        status_bits_in;
  logic [3:0]  wb_rd_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_data_in;
  logic [3:0]  flags_in;
  logic [31:0] pc_in;
  logic [3:0]  raddr_a, raddr_b, raddr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [3:0]  flags_out, cond_flags;
  logic        pc_write_out;
  logic [31:0] pc_write_data;
  logic        wb_valid_out;
  logic [3:0]  wb_rd_out;
  logic [31:0] wb_data_out;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PC_INDEX(15)) dut (
    .clk(clk), .reset(reset),
    .reg_write_enable_in(reg_write_enable_in),
    .mem_to_reg_select_in(mem_to_reg_select_in),
    .status_bits_in(status_bits_in),
    .wb_rd_in(wb_rd_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .flags_in(flags_in), .pc_in(pc_in),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .raddr_c(raddr_c),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rdata_c(rdata_c),
    .flags_out(flags_out), .cond_flags(cond_flags),
    .pc_write_out(pc_write_out), .pc_write_data(pc_write_data),
    .wb_valid_out(wb_valid_out), .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_enable_in  = 1'b0;
    mem_to_reg_select_in = 1'b0;
    status_bits_in       = 1'b0;
    wb_rd_in             = 4'd0;
    alu_result_in        = 32'd0;
    mem_data_in          = 32'd0;
    flags_in             = 4'd0;
  endtask

  task automatic test_reset();
    // Dirty the state first: several register writes, a PC write and flags.
    reset = 1'b0;
    for (int i = 1; i < 15; i++) begin
      reg_write_enable_in = 1'b1;
      wb_rd_in            = 4'(i);
      alu_result_in       = $urandom | 32'h1;
      status_bits_in      = 1'b1;
      flags_in            = 4'hF;
      tick();
    end
    wb_rd_in = 4'd15; alu_result_in = 32'h200;
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      raddr_a = 4'(i);
      #1;
      n_cmp++;
      if (rdata_a !== 32'd0) begin
        n_err++;
        $display("FAIL reset_reg R%0d: got %h expected %h", i, rdata_a, 32'd0);
      end
    end
    n_cmp++; if (flags_out !== 4'd0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", flags_out); end
    n_cmp++; if (pc_write_out !== 1'b0) begin n_err++; $display("FAIL reset_pc_write: got %b expected 0", pc_write_out); end
    n_cmp++; if (pc_write_data !== 32'd0) begin n_err++; $display("FAIL reset_pc_data: got %h expected 0", pc_write_data); end
    n_cmp++; if (wb_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_out); end
    n_cmp++; if (wb_rd_out !== 4'd0 || wb_data_out !== 32'd0) begin n_err++; $display("FAIL reset_wb_fwd: got rd=%0d data=%h expected 0/0", wb_rd_out, wb_data_out); end
  endtask

  task automatic test_write_bypass();
    reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b0;
    wb_rd_in = 4'd3; alu_result_in = 32'h0000_1234; mem_data_in = 32'h5555_5555;
    raddr_a = 4'd3;
    #1;
    n_cmp++; if (rdata_a !== 32'h1234) begin n_err++; $display("FAIL bypass_r3: got %h expected %h", rdata_a, 32'h1234); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rdata_a !== 32'h1234) begin n_err++; $display("FAIL stored_r3: got %h expected %h", rdata_a, 32'h1234); end
    n_cmp++; if (wb_valid_out !== 1'b1) begin n_err++; $display("FAIL wb_valid_r3: got %b expected 1", wb_valid_out); end
    n_cmp++; if (wb_rd_out !== 4'd3) begin n_err++; $display("FAIL wb_rd_r3: got %0d expected 3", wb_rd_out); end
    n_cmp++; if (wb_data_out !== 32'h1234) begin n_err++; $display("FAIL wb_data_r3: got %h expected %h", wb_data_out, 32'h1234); end
    tick();
    n_cmp++; if (wb_valid_out !== 1'b0) begin n_err++; $display("FAIL wb_valid_drop: got %b expected 0", wb_valid_out); end
    n_cmp++; if (wb_rd_out !== 4'd3 || wb_data_out !== 32'h1234) begin n_err++; $display("FAIL wb_hold: got rd=%0d data=%h expected 3/00001234", wb_rd_out, wb_data_out); end
  endtask

  task automatic test_mem_select();
    reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b1;
    wb_rd_in = 4'd7; alu_result_in = 32'h1; mem_data_in = 32'hDEAD_BEEF;
    raddr_a = 4'd7; raddr_b = 4'd7; raddr_c = 4'd7;
    #1;
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_bypass_a: got %h expected deadbeef", rdata_a); end
    n_cmp++; if (rdata_b !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_bypass_b: got %h expected deadbeef", rdata_b); end
    n_cmp++; if (rdata_c !== 32'hDEADBEEF) begin n_err++; $display("FAIL mem_bypass_c: got %h expected deadbeef", rdata_c); end
    raddr_b = 4'd3;
    #1;
    n_cmp++; if (rdata_b !== 32'h1234) begin n_err++; $display("FAIL no_bypass_other: got %h expected 00001234", rdata_b); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_r7: got %h expected deadbeef", rdata_a); end
    n_cmp++; if (wb_data_out !== 32'hDEADBEEF || wb_rd_out !== 4'd7) begin n_err++; $display("FAIL wb_fwd_r7: got rd=%0d data=%h expected 7/deadbeef", wb_rd_out, wb_data_out); end
  endtask

  task automatic test_pc_write();
    reg_write_enable_in = 1'b1; mem_to_reg_select_in = 1'b0;
    wb_rd_in = 4'd15; alu_result_in = 32'h0000_0400; pc_in = 32'h0000_0108;
    raddr_b = 4'd15;
    #1;
    n_cmp++; if (rdata_b !== 32'h108) begin n_err++; $display("FAIL r15_read: got %h expected 00000108", rdata_b); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (pc_write_out !== 1'b1) begin n_err++; $display("FAIL pc_pulse: got %b expected 1", pc_write_out); end
    n_cmp++; if (pc_write_data !== 32'h400) begin n_err++; $display("FAIL pc_data: got %h expected 00000400", pc_write_data); end
    n_cmp++; if (wb_valid_out !== 1'b0) begin n_err++; $display("FAIL pc_wb_valid: got %b expected 0", wb_valid_out); end
    n_cmp++; if (rdata_b !== 32'h108) begin n_err++; $display("FAIL r15_after: got %h expected 00000108", rdata_b); end
    n_cmp++; if (wb_rd_out !== 4'd7) begin n_err++; $display("FAIL pc_wb_rd_hold: got %0d expected 7", wb_rd_out); end
    tick();
    n_cmp++; if (pc_write_out !== 1'b0) begin n_err++; $display("FAIL pc_pulse_end: got %b expected 0", pc_write_out); end
  endtask

  task automatic test_flags();
    status_bits_in = 1'b1; flags_in = 4'b0110;
    #1;
    n_cmp++; if (cond_flags !== 4'b0110) begin n_err++; $display("FAIL cond_bypass: got %b expected 0110", cond_flags); end
    n_cmp++; if (flags_out !== 4'b0000) begin n_err++; $display("FAIL flags_pre: got %b expected 0000", flags_out); end
    tick();
    status_bits_in = 1'b0; flags_in = 4'b1111;
    #1;
    n_cmp++; if (flags_out !== 4'b0110) begin n_err++; $display("FAIL flags_commit: got %b expected 0110", flags_out); end
    n_cmp++; if (cond_flags !== 4'b0110) begin n_err++; $display("FAIL cond_hold: got %b expected 0110", cond_flags); end
    tick();
    n_cmp++; if (flags_out !== 4'b0110) begin n_err++; $display("FAIL flags_hold: got %b expected 0110", flags_out); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    // Register write and flag update in the same cycle, then a second write.
    reg_write_enable_in = 1'b1; wb_rd_in = 4'd9; alu_result_in = 32'hA5A5_0001;
    status_bits_in = 1'b1; flags_in = 4'b1001;
    tick();
    wb_rd_in = 4'd0; alu_result_in = 32'h0BAD_F00D; status_bits_in = 1'b0;
    raddr_a = 4'd9; raddr_c = 4'd0;
    #1;
    n_cmp++; if (rdata_a !== 32'hA5A50001) begin n_err++; $display("FAIL b2b_r9: got %h expected a5a50001", rdata_a); end
    n_cmp++; if (rdata_c !== 32'h0BADF00D) begin n_err++; $display("FAIL b2b_r0_bypass: got %h expected 0badf00d", rdata_c); end
    n_cmp++; if (flags_out !== 4'b1001) begin n_err++; $display("FAIL b2b_flags: got %b expected 1001", flags_out); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rdata_c !== 32'h0BADF00D) begin n_err++; $display("FAIL b2b_r0_stored: got %h expected 0badf00d", rdata_c); end
    n_cmp++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 4'd0) begin n_err++; $display("FAIL b2b_fwd: got valid=%b rd=%0d expected 1/0", wb_valid_out, wb_rd_out); end
  endtask

  task automatic test_reset_discard();
    reset = 1'b1; reg_write_enable_in = 1'b1; wb_rd_in = 4'd5;
    alu_result_in = 32'hFFFF_FFFF; status_bits_in = 1'b1; flags_in = 4'b1111;
    tick();
    reset = 1'b0;
    idle_inputs();
    raddr_a = 4'd5; raddr_b = 4'd9;
    #1;
    n_cmp++; if (rdata_a !== 32'd0) begin n_err++; $display("FAIL discard_r5: got %h expected 0", rdata_a); end
    n_cmp++; if (rdata_b !== 32'd0) begin n_err++; $display("FAIL discard_r9: got %h expected 0", rdata_b); end
    n_cmp++; if (flags_out !== 4'd0) begin n_err++; $display("FAIL discard_flags: got %b expected 0000", flags_out); end
    n_cmp++; if (wb_valid_out !== 1'b0 || pc_write_out !== 1'b0) begin n_err++; $display("FAIL discard_pulses: got valid=%b pc=%b expected 0/0", wb_valid_out, pc_write_out); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    pc_in = 32'h0000_0008;
    raddr_a = 4'd0; raddr_b = 4'd0; raddr_c = 4'd0;
    tick();
    tick();
    test_reset();
    test_write_bypass();
    test_mem_select();
    test_pc_write();
    test_flags();
    test_back_to_back();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Consumer end of the MEM/WB pipeline register: takes the latched writeback control and data and commits results to architectural state.
- Owns the 16x32 ARM register file (R0–R14 stored; R15 reads return the PC), the NZCV status register and a same-cycle write-through bypass for the decode-stage read ports.
- Generates a one-cycle PC-redirect pulse when writeback targets R15.

Parameters:
DATA_WIDTH, 32, width of registers and data paths
ADDR_WIDTH, 4, register index width (16 architectural registers)
PC_INDEX, 15, register index treated as the program counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
reg_write_enable_in  input  1  WB-stage register write request
mem_to_reg_select_in  input  1  1 = write mem_data_in, 0 = write alu_result_in
status_bits_in  input  1  1 = commit flags_in to NZCV this cycle
wb_rd_in  input  ADDR_WIDTH  destination register index
alu_result_in  input  DATA_WIDTH  ALU result from MEM/WB
mem_data_in  input  DATA_WIDTH  load data from MEM/WB
flags_in  input  4  NZCV produced by the instruction ({N,Z,C,V})
pc_in  input  DATA_WIDTH  current PC+8 value returned for R15 reads
raddr_a, raddr_b, raddr_c  input  ADDR_WIDTH  decode-stage read indices (Rn, Rm, Rd for stores)
rdata_a, rdata_b, rdata_c  output  DATA_WIDTH  combinational read data, bypassed
flags_out  output  4  architectural NZCV (registered)
cond_flags  output  4  NZCV for condition evaluation, bypassed
pc_write_out  output  1  one-cycle pulse: WB wrote R15
pc_write_data  output  DATA_WIDTH  target address accompanying pc_write_out
wb_valid_out  output  1  registered: a register write committed last cycle
wb_rd_out  output  ADDR_WIDTH  registered index of last committed write
wb_data_out  output  DATA_WIDTH  registered data of last committed write (forwarding source)

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high; reset takes priority over every write in that cycle.
- Reset values:
  - R0–R14 = 0, NZCV = 0.
  - pc_write_out = 0, pc_write_data = 0.
  - wb_valid_out = 0, wb_rd_out = 0, wb_data_out = 0.
- Writeback data (combinational): wb_data = mem_to_reg_select_in ? mem_data_in : alu_result_in.
- Register commit, at posedge when !reset and reg_write_enable_in:
  - wb_rd_in != PC_INDEX: reg[wb_rd_in] <= wb_data.
  - wb_rd_in == PC_INDEX: no storage update; pc_write_out <= 1 and pc_write_data <= wb_data for exactly the next cycle, otherwise pc_write_out <= 0. Latency 1 cycle.
- Forwarding outputs, every non-reset cycle:
  - wb_valid_out <= reg_write_enable_in && wb_rd_in != PC_INDEX.
  - When valid, wb_rd_out and wb_data_out update; otherwise they hold their previous values.
- Flags: at posedge when !reset and status_bits_in, NZCV <= flags_in; otherwise hold. flags_out reflects the register (latency 1).
- Flag bypass: cond_flags = status_bits_in ? flags_in : NZCV, combinational.
- Reads (combinational, per port x in a, b, c):
  - raddr_x == PC_INDEX: rdata_x = pc_in, never bypassed.
  - Otherwise, if reg_write_enable_in && wb_rd_in == raddr_x: rdata_x = wb_data (write-through).
  - Otherwise: rdata_x = reg[raddr_x].
- Simultaneous events: all three ports may read the register being written, and all see the bypassed value. A flag update and a register write in the same cycle are independent and both commit.
- Reset mid-operation: a pending write or flag update in the reset cycle is discarded. Bypass paths stay active combinationally; read values during reset are don't-care for verification.
- No storage for R15. No banked registers. No X propagation: all registers are reset.

Test Plan:
- Reset asserted 2 cycles after random writes -> all raddr 0–14 read 0; flags_out=0; pc_write_out=0; wb_valid_out=0.
- Write R3 with alu_result_in=0x0000_1234 (mem_to_reg=0), raddr_a=3 in the same cycle -> rdata_a=0x1234 immediately; the next cycle, with enable low, rdata_a=0x1234, wb_valid_out=1, wb_rd_out=3, wb_data_out=0x1234.
- mem_to_reg=1, mem_data_in=0xDEAD_BEEF, alu_result_in=0x1, rd=7; raddr_a=raddr_b=raddr_c=7 -> all three read 0xDEADBEEF, and R7 stores 0xDEADBEEF.
- Write rd=15 with data 0x0000_0400, pc_in=0x0000_0108, raddr_b=15 -> rdata_b=0x108; the next cycle pc_write_out=1 and pc_write_data=0x400; the cycle after, pc_write_out=0; wb_valid_out=0.
- status_bits_in=1, flags_in=4'b0110 -> cond_flags=0110 the same cycle, flags_out=0110 the next cycle; then status_bits_in=0, flags_in=1111 -> flags_out and cond_flags stay 0110.
- reset=1 with reg_write_enable_in=1, rd=5, data 0xFFFF_FFFF and status_bits_in=1 -> after release, R5=0 and flags_out=0.
